dtc_share_arbiter: RTL and testbench

DTC_SHARE_ARBITER -- requirements
Module: dtc_share_arbiter

---
 rtl/dtc_share_arbiter_if.sv | 31 +++
 rtl/dtc_share_arbiter.sv | 118 +++++++++++
 tb/tb_dtc_share_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtc_share_arbiter_if.sv
// Signal bundle between the requesters, the external classifier, the result consumer
// and the arbiter that shares that one classifier among the requesters.
interface dtc_share_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 10,
   parameter int OUT_W = 3
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*IN_W-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic [IN_W-1:0]      cls_inp;
   logic [OUT_W-1:0]     cls_outp;
   logic                 res_valid;
   logic                 res_ready;
   logic [OUT_W-1:0]     res_class;
   logic [2:0]           res_id;
   logic                 busy;
   logic [15:0]          served_cnt;

   // The environment side: requesters, classifier and consumer.
   modport master (
      output req_valid, req_data, cls_outp, res_ready,
      input  req_ready, cls_inp, res_valid, res_class, res_id, busy, served_cnt
   );

   // The arbiter side.
   modport slave (
      input  req_valid, req_data, cls_outp, res_ready,
      output req_ready, cls_inp, res_valid, res_class, res_id, busy, served_cnt
   );
endinterface

// File: rtl/dtc_share_arbiter.sv
// Round-robin arbiter time-sharing one combinational classifier among NREQ requesters:
// grant, evaluate for one cycle, then hold the result until the consumer takes it.
module dtc_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 10,
   parameter int OUT_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   dtc_share_arbiter_if.slave bus
);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("dtc_share_arbiter: NREQ must be in 2..8");
   end

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      HOLD
   } state_t;

   state_t           state_q;
   logic [IN_W-1:0]  clsInp_q;
   logic [2:0]       gntId_q;
   logic [2:0]       lastGrant_q;
   logic             resValid_q;
   logic [OUT_W-1:0] resClass_q;
   logic [2:0]       resId_q;
   logic [15:0]      servedCnt_q;

   logic             grantHit_d;
   logic [2:0]       grantId_d;
   logic [IN_W-1:0]  grantData_d;
   logic [NREQ-1:0]  reqReady_d;
   logic             hitUpper;
   logic [2:0]       idUpper;
   logic [2:0]       idAny;

   // Round robin without a rotator: prefer the lowest valid index above the last
   // grant, otherwise wrap to the lowest valid index overall.
   always_comb begin
      hitUpper   = 1'b0;
      idUpper    = '0;
      grantHit_d = 1'b0;
      idAny      = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i] && !hitUpper && (3'(i) > lastGrant_q)) begin
            hitUpper = 1'b1;
            idUpper  = 3'(i);
         end
         if (bus.req_valid[i] && !grantHit_d) begin
            grantHit_d = 1'b1;
            idAny      = 3'(i);
         end
      end
      grantId_d = hitUpper ? idUpper : idAny;
   end

   always_comb begin
      grantData_d = '0;
      reqReady_d  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (3'(i) == grantId_d) begin
            grantData_d   = bus.req_data[i*IN_W +: IN_W];
            reqReady_d[i] = grantHit_d && (state_q == IDLE);
         end
      end
   end

   // Reset in EVAL/HOLD simply drops the in-flight result; nothing is counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         clsInp_q    <= '0;
         gntId_q     <= '0;
         lastGrant_q <= 3'(NREQ - 1);
         resValid_q  <= 1'b0;
         resClass_q  <= '0;
         resId_q     <= '0;
         servedCnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grantHit_d) begin
                  clsInp_q    <= grantData_d;
                  gntId_q     <= grantId_d;
                  lastGrant_q <= grantId_d;
                  state_q     <= EVAL;
               end
            end
            EVAL: begin
               resClass_q <= bus.cls_outp;
               resId_q    <= gntId_q;
               resValid_q <= 1'b1;
               state_q    <= HOLD;
            end
            HOLD: begin
               if (bus.res_ready) begin
                  resValid_q  <= 1'b0;
                  servedCnt_q <= servedCnt_q + 16'd1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = reqReady_d;
   assign bus.cls_inp    = clsInp_q;
   assign bus.res_valid  = resValid_q;
   assign bus.res_class  = resClass_q;
   assign bus.res_id     = resId_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.served_cnt = servedCnt_q;

endmodule

// File: tb/tb_dtc_share_arbiter.sv
// Scoreboard bench for dtc_share_arbiter: expected results are queued at grant time
// from a small classifier/round-robin model and popped when the result appears.
module tb_dtc_share_arbiter;
   localparam int NREQ  = 4;
   localparam int IN_W  = 10;
   localparam int OUT_W = 3;

   typedef struct packed {
      logic [2:0]       id;
      logic [OUT_W-1:0] cls;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   modelLast;
   int   modelServed;
   exp_t expQ[$];

   always #5 clk = ~clk;

   dtc_share_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   dtc_share_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference classifier: a small decision tree on bits 7, 8, 4 and 3.
   function automatic logic [OUT_W-1:0] classify(logic [IN_W-1:0] v);
      if (!v[7])     return v[3] ? 3'b001 : 3'b111;
      else if (v[8]) return 3'b100;
      else if (v[4]) return 3'b011;
      else           return 3'b010;
   endfunction

   assign bus.cls_outp = classify(bus.cls_inp);

   function automatic int rrPick(logic [NREQ-1:0] mask, int last);
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (last + k) % NREQ;
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic applyStimulus(logic [NREQ-1:0] valid, logic [NREQ*IN_W-1:0] data, logic rr);
      bus.req_valid = valid;
      bus.req_data  = data;
      bus.res_ready = rr;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus('0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelLast   = NREQ - 1;
      modelServed = 0;
      expQ.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus('0, '0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.req_ready !== '0) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 0", bus.req_ready); end
      checks++; if (bus.cls_inp !== '0) begin errors++; $display("[TB] FAIL reset_cls_inp got %h want 0", bus.cls_inp); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got %b want 0", bus.res_valid); end
      checks++; if (bus.res_class !== '0) begin errors++; $display("[TB] FAIL reset_res_class got %b want 0", bus.res_class); end
      checks++; if (bus.res_id !== '0) begin errors++; $display("[TB] FAIL reset_res_id got %0d want 0", bus.res_id); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.served_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_served got %h want 0000", bus.served_cnt); end
      rst = 1'b0;
      modelLast   = NREQ - 1;
      modelServed = 0;
      expQ.delete();
   endtask

   // Driven straight after reset release so the grant lands on the very next edge.
   task automatic test_single();
      logic [NREQ*IN_W-1:0] data;
      exp_t e;
      int   id;
      data = '0;
      applyStimulus(4'b0001, data, 1'b1);
      #1;
      id = rrPick(4'b0001, modelLast);
      checks++; if (bus.req_ready !== (NREQ'(1) << id)) begin errors++; $display("[TB] FAIL single_grant got %b want %b", bus.req_ready, NREQ'(1) << id); end
      e.id = 3'(id); e.cls = classify(data[id*IN_W +: IN_W]); expQ.push_back(e); modelLast = id;
      @(negedge clk); #1;
      checks++; if (bus.cls_inp !== 10'h000) begin errors++; $display("[TB] FAIL single_cls_inp got %h want 000", bus.cls_inp); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", bus.busy); end
      checks++; if (bus.req_ready !== '0) begin errors++; $display("[TB] FAIL single_eval_ready got %b want 0", bus.req_ready); end
      applyStimulus('0, data, 1'b1);
      @(negedge clk); #1;
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_res_valid got %b want 1", bus.res_valid); end
      if (expQ.size() == 0) begin checks++; errors++; $display("[TB] FAIL single_scoreboard got empty want 1 entry"); end
      else begin
         e = expQ.pop_front();
         checks++; if (bus.res_class !== e.cls) begin errors++; $display("[TB] FAIL single_res_class got %b want %b", bus.res_class, e.cls); end
         checks++; if (bus.res_id !== e.id) begin errors++; $display("[TB] FAIL single_res_id got %0d want %0d", bus.res_id, e.id); end
      end
      @(negedge clk); #1;
      modelServed++;
      checks++; if (bus.served_cnt !== 16'(modelServed)) begin errors++; $display("[TB] FAIL single_served got %0d want %0d", bus.served_cnt, modelServed); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_round_robin();
      logic [NREQ*IN_W-1:0] vec;
      int   order[5];
      int   grants;
      exp_t e;
      order = '{0, 1, 2, 3, 0};
      grants = 0;
      doReset();
      vec = {10'h090, 10'h180, 10'h008, 10'h000};
      applyStimulus(4'b1111, vec, 1'b1);
      for (int c = 0; c < 15; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         if (bus.req_ready !== '0) begin
            checks++;
            if (grants >= 5 || c != grants * 3 || bus.req_ready !== (NREQ'(1) << order[grants])) begin
               errors++; $display("[TB] FAIL rr_grant got %b at cycle %0d grant %0d", bus.req_ready, c, grants);
            end else begin
               e.id = 3'(order[grants]); e.cls = classify(vec[order[grants]*IN_W +: IN_W]);
               expQ.push_back(e); modelLast = order[grants];
            end
            grants++;
         end
         if (bus.res_valid === 1'b1) begin
            if (expQ.size() == 0) begin checks++; errors++; $display("[TB] FAIL rr_scoreboard got unexpected result id %0d", bus.res_id); end
            else begin
               e = expQ.pop_front();
               checks++; if (bus.res_class !== e.cls || bus.res_id !== e.id) begin errors++; $display("[TB] FAIL rr_result got %0d/%b want %0d/%b", bus.res_id, bus.res_class, e.id, e.cls); end
            end
         end
      end
      @(negedge clk); #1;
      applyStimulus('0, vec, 1'b0);
      modelServed = 5;
      checks++; if (bus.served_cnt !== 16'd5) begin errors++; $display("[TB] FAIL rr_served got %0d want 5", bus.served_cnt); end
      checks++; if (grants !== 5) begin errors++; $display("[TB] FAIL rr_grant_count got %0d want 5", grants); end
      checks++; if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL rr_leftover got %0d want 0", expQ.size()); end
   endtask

   // Other requesters raise valid during EVAL/HOLD; they must be ignored.
   task automatic test_hold();
      logic [NREQ*IN_W-1:0] vec;
      exp_t e;
      int   id;
      vec = '0;
      vec[2*IN_W +: IN_W] = 10'h080;
      e = '0;
      @(negedge clk);
      applyStimulus(4'b0100, vec, 1'b0);
      #1;
      id = rrPick(4'b0100, modelLast);
      checks++; if (bus.req_ready !== (NREQ'(1) << id)) begin errors++; $display("[TB] FAIL hold_grant got %b want %b", bus.req_ready, NREQ'(1) << id); end
      e.id = 3'(id); e.cls = classify(vec[id*IN_W +: IN_W]); expQ.push_back(e); modelLast = id;
      @(negedge clk); #1;
      applyStimulus(4'b1111, vec, 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         if (c == 0) begin
            if (expQ.size() == 0) begin checks++; errors++; $display("[TB] FAIL hold_scoreboard got empty want 1 entry"); end
            else e = expQ.pop_front();
         end
         checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_res_valid cycle %0d got %b want 1", c, bus.res_valid); end
         checks++; if (bus.res_class !== e.cls) begin errors++; $display("[TB] FAIL hold_res_class cycle %0d got %b want %b", c, bus.res_class, e.cls); end
         checks++; if (bus.res_id !== e.id) begin errors++; $display("[TB] FAIL hold_res_id cycle %0d got %0d want %0d", c, bus.res_id, e.id); end
         checks++; if (bus.req_ready !== '0) begin errors++; $display("[TB] FAIL hold_req_ready cycle %0d got %b want 0", c, bus.req_ready); end
         checks++; if (bus.cls_inp !== 10'h080) begin errors++; $display("[TB] FAIL hold_cls_inp cycle %0d got %h want 080", c, bus.cls_inp); end
      end
      applyStimulus('0, vec, 1'b1);
      @(negedge clk); #1;
      modelServed++;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release got %b want 0", bus.res_valid); end
      checks++; if (bus.served_cnt !== 16'(modelServed)) begin errors++; $display("[TB] FAIL hold_served got %0d want %0d", bus.served_cnt, modelServed); end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus.served_cnt !== 16'(modelServed)) begin errors++; $display("[TB] FAIL idle_res_ready got %0d want %0d", bus.served_cnt, modelServed); end
      applyStimulus('0, vec, 1'b0);
   endtask

   task automatic test_reset_in_hold();
      logic [NREQ*IN_W-1:0] vec;
      exp_t e;
      int   id;
      doReset();
      vec = {10'h190, 10'h008, 10'h0A0, 10'h090};
      applyStimulus(4'b0100, vec, 1'b0);
      #1;
      id = rrPick(4'b0100, modelLast);
      checks++; if (bus.req_ready !== (NREQ'(1) << id)) begin errors++; $display("[TB] FAIL rsthold_grant got %b want %b", bus.req_ready, NREQ'(1) << id); end
      modelLast = id;
      @(negedge clk); #1;
      applyStimulus('0, vec, 1'b0);
      @(negedge clk); #1;
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_in_hold got %b want 1", bus.res_valid); end
      rst = 1'b1;
      #1;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_async_valid got %b want 0", bus.res_valid); end
      checks++; if (bus.served_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL rsthold_served got %0d want 0", bus.served_cnt); end
      modelLast = NREQ - 1;
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b1111, vec, 1'b1);
      #1;
      id = rrPick(4'b1111, modelLast);
      checks++; if (bus.req_ready !== (NREQ'(1) << id)) begin errors++; $display("[TB] FAIL rsthold_next_grant got %b want %b", bus.req_ready, NREQ'(1) << id); end
      e.id = 3'(id); e.cls = classify(vec[id*IN_W +: IN_W]); expQ.push_back(e); modelLast = id;
      @(negedge clk); #1;
      applyStimulus('0, vec, 1'b1);
      @(negedge clk); #1;
      if (expQ.size() == 0) begin checks++; errors++; $display("[TB] FAIL rsthold_scoreboard got empty want 1 entry"); end
      else begin
         e = expQ.pop_front();
         checks++; if (bus.res_valid !== 1'b1 || bus.res_class !== e.cls || bus.res_id !== e.id) begin errors++; $display("[TB] FAIL rsthold_result got %b %0d/%b want 1 %0d/%b", bus.res_valid, bus.res_id, bus.res_class, e.id, e.cls); end
      end
      @(negedge clk); #1;
      modelServed = 1;
      checks++; if (bus.served_cnt !== 16'(modelServed)) begin errors++; $display("[TB] FAIL rsthold_served_after got %0d want %0d", bus.served_cnt, modelServed); end
   endtask

   task automatic test_wrap();
      logic [NREQ*IN_W-1:0] vec;
      exp_t e;
      int   id;
      vec = '0;
      vec[3*IN_W +: IN_W] = 10'h190;
      @(negedge clk);
      force dut.servedCnt_q = 16'hFFFF;
      #1;
      release dut.servedCnt_q;
      #1;
      checks++; if (bus.served_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload got %h want ffff", bus.served_cnt); end
      applyStimulus(4'b1000, vec, 1'b1);
      #1;
      id = rrPick(4'b1000, modelLast);
      checks++; if (bus.req_ready !== (NREQ'(1) << id)) begin errors++; $display("[TB] FAIL wrap_grant got %b want %b", bus.req_ready, NREQ'(1) << id); end
      e.id = 3'(id); e.cls = classify(vec[id*IN_W +: IN_W]); expQ.push_back(e); modelLast = id;
      @(negedge clk); #1;
      applyStimulus('0, vec, 1'b1);
      @(negedge clk); #1;
      if (expQ.size() == 0) begin checks++; errors++; $display("[TB] FAIL wrap_scoreboard got empty want 1 entry"); end
      else begin
         e = expQ.pop_front();
         checks++; if (bus.res_valid !== 1'b1 || bus.res_class !== e.cls || bus.res_id !== e.id) begin errors++; $display("[TB] FAIL wrap_result got %b %0d/%b want 1 %0d/%b", bus.res_valid, bus.res_id, bus.res_class, e.id, e.cls); end
      end
      @(negedge clk); #1;
      checks++; if (bus.served_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_served got %h want 0000", bus.served_cnt); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got no finish want finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_hold();
      test_reset_in_hold();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
